// File: rtl/pool_sequencer_pkg.sv
// rtl/pool_sequencer_pkg.sv - shared state encoding and geometry helpers for the pooling sequencer
package pool_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int CNTW = 16;

    // Never returns 0 so a degenerate map still yields a legal port width.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

endpackage

// File: rtl/pool_sequencer_addr_gen.sv
// rtl/pool_sequencer_addr_gen.sv - nested window/pixel counters and buffer address generation
module pool_sequencer_addr_gen
    import pool_sequencer_pkg::*;
#(
    parameter int W   = 28,
    parameter int H   = 28,
    parameter int C   = 4,
    parameter int KW  = 2,
    parameter int KH  = 2,
    parameter int S   = 2,
    parameter int IAW = 12,
    parameter int OAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           step_k,
    input  logic           step_win,
    output logic           k_first,
    output logic           k_last,
    output logic           win_last,
    output logic [IAW-1:0] rd_addr,
    output logic [OAW-1:0] wr_addr
);

    localparam int OW = out_dim(W, KW, S);
    localparam int OH = out_dim(H, KH, S);

    logic [CNTW-1:0] c, oy, ox, ky, kx;
    logic            kx_last, ky_last, ox_last, oy_last, c_last;

    assign kx_last  = (kx == CNTW'(KW - 1));
    assign ky_last  = (ky == CNTW'(KH - 1));
    assign ox_last  = (ox == CNTW'(OW - 1));
    assign oy_last  = (oy == CNTW'(OH - 1));
    assign c_last   = (c  == CNTW'(C - 1));
    assign k_first  = (kx == '0) && (ky == '0);
    assign k_last   = kx_last && ky_last;
    assign win_last = ox_last && oy_last && c_last;

    // All counters wrap to zero at the end of their range, so a finished pass leaves them ready for the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            c  <= '0;
            oy <= '0;
            ox <= '0;
            ky <= '0;
            kx <= '0;
        end else begin
            if (step_k) begin
                if (kx_last) begin
                    kx <= '0;
                    ky <= ky_last ? '0 : ky + CNTW'(1);
                end else begin
                    kx <= kx + CNTW'(1);
                end
            end
            if (step_win) begin
                if (ox_last) begin
                    ox <= '0;
                    if (oy_last) begin
                        oy <= '0;
                        c  <= c_last ? '0 : c + CNTW'(1);
                    end else begin
                        oy <= oy + CNTW'(1);
                    end
                end else begin
                    ox <= ox + CNTW'(1);
                end
            end
        end
    end

    assign rd_addr = IAW'(c) * IAW'(H * W)
                   + (IAW'(oy) * IAW'(S) + IAW'(ky)) * IAW'(W)
                   + IAW'(ox) * IAW'(S) + IAW'(kx);
    assign wr_addr = OAW'(c) * OAW'(OH * OW) + OAW'(oy) * OAW'(OW) + OAW'(ox);

endmodule

// File: rtl/pool_sequencer.sv
// rtl/pool_sequencer.sv - max-pooling sequencer: window walk, running signed max, write handshake
module pool_sequencer
    import pool_sequencer_pkg::*;
#(
    parameter int  BITWIDTH    = 16,
    parameter int  DATAWIDTH   = 28,
    parameter int  DATAHEIGHT  = 28,
    parameter int  DATACHANNEL = 4,
    parameter int  KWIDTH      = 2,
    parameter int  KHEIGHT     = 2,
    parameter int  STRIDE      = 2,
    localparam int OW  = out_dim(DATAWIDTH, KWIDTH, STRIDE),
    localparam int OH  = out_dim(DATAHEIGHT, KHEIGHT, STRIDE),
    localparam int IAW = clog2(DATACHANNEL * DATAHEIGHT * DATAWIDTH),
    localparam int OAW = clog2(DATACHANNEL * OH * OW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [IAW-1:0]      rd_addr,
    input  logic [BITWIDTH-1:0] rd_data,
    output logic                wr_en,
    output logic [OAW-1:0]      wr_addr,
    output logic [BITWIDTH-1:0] wr_data,
    input  logic                wr_ready
);

    state_t              state, state_nx;
    logic                step_k, step_win;
    logic                k_first, k_last, win_last;
    logic                rd_valid, rd_first;
    logic [BITWIDTH-1:0] acc;

    pool_sequencer_addr_gen #(
        .W   (DATAWIDTH),
        .H   (DATAHEIGHT),
        .C   (DATACHANNEL),
        .KW  (KWIDTH),
        .KH  (KHEIGHT),
        .S   (STRIDE),
        .IAW (IAW),
        .OAW (OAW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .step_k   (step_k),
        .step_win (step_win),
        .k_first  (k_first),
        .k_last   (k_last),
        .win_last (win_last),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        step_k   = 1'b0;
        step_win = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                rd_en  = 1'b1;
                step_k = 1'b1;
                if (k_last) begin
                    state_nx = S_LAST;
                end
            end
            S_LAST: begin
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if (wr_ready) begin
                    step_win = 1'b1;
                    state_nx = win_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy    = (state == S_READ) || (state == S_LAST) || (state == S_WRITE);
    assign done    = (state == S_DONE);
    assign wr_data = acc;

    // rd_data trails rd_en by one cycle; rd_first marks the pixel that seeds a new window.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            acc      <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_first <= rd_en && k_first;
            if (rd_valid) begin
                if (rd_first || ($signed(rd_data) > $signed(acc))) begin
                    acc <= rd_data;
                end
            end
        end
    end

endmodule
